// File: rtl/hsmon_pkg.sv
// Shared definitions for the multi-channel req/ack handshake monitor.
package hsmon_pkg;

    localparam int unsigned RULE_SPURIOUS = 0;
    localparam int unsigned RULE_EARLY    = 1;
    localparam int unsigned RULE_TIMEOUT  = 2;
    localparam int unsigned RULE_REQ_DROP = 3;
    localparam int unsigned RULE_W        = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2,
        TOUT     = 2'd3
    } ch_state_e;

endpackage

// File: rtl/hsmon_channel.sv
// One req/ack channel: protocol FSM, ack edge detect, latency counter,
// registered fire pulses, sticky flags and a saturating violation counter.
module hsmon_channel
    import hsmon_pkg::*;
#(
    parameter int unsigned MIN_ACK = 2,
    parameter int unsigned MAX_ACK = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clr,
    input  logic              req,
    input  logic              ack,
    output logic [RULE_W-1:0] fire,
    output logic [RULE_W-1:0] err_sticky,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int unsigned LAT_W       = (MAX_ACK >= 1) ? $clog2(MAX_ACK + 1) : 1;
    localparam bit          EARLY_AT_L0 = (MIN_ACK > 0);

    ch_state_e         r_state;
    logic              r_ack_q;
    logic [LAT_W-1:0]  r_lat;
    logic [RULE_W-1:0] r_fire;
    logic [RULE_W-1:0] r_sticky;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    ch_state_e         w_next_state;
    logic [LAT_W-1:0]  w_next_lat;
    logic [RULE_W-1:0] w_viol;
    logic              w_ack_edge;
    logic              w_any_viol;
    logic              w_cnt_sat;

    // r_lat holds the latency that will apply at the next sampling edge
    always_comb begin
        w_next_state = r_state;
        w_next_lat   = r_lat;
        w_viol       = '0;
        w_ack_edge   = ack & ~r_ack_q;
        if (!enable) begin
            w_next_state = IDLE;
            w_next_lat   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        w_next_lat = LAT_W'(1);
                        if (w_ack_edge) begin
                            w_viol[RULE_EARLY] = EARLY_AT_L0;
                            w_next_state       = DONE;
                        end else begin
                            w_next_state = WAIT_ACK;
                        end
                    end else if (w_ack_edge) begin
                        w_viol[RULE_SPURIOUS] = 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (w_ack_edge) begin
                        w_viol[RULE_EARLY] = (r_lat < LAT_W'(MIN_ACK));
                        w_next_state       = DONE;
                    end else if (!req) begin
                        w_viol[RULE_REQ_DROP] = 1'b1;
                        w_next_state          = IDLE;
                    end else if (r_lat == LAT_W'(MAX_ACK)) begin
                        w_viol[RULE_TIMEOUT] = 1'b1;
                        w_next_state         = TOUT;
                    end else begin
                        w_next_lat = r_lat + LAT_W'(1);
                    end
                end
                DONE: begin
                    w_viol[RULE_SPURIOUS] = w_ack_edge;
                    if (!req) begin
                        w_next_state = IDLE;
                    end
                end
                TOUT: begin
                    if (!req) begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    assign w_any_viol = |w_viol;
    assign w_cnt_sat  = (r_cnt == {CNT_W{1'b1}});

    // A violation on the clearing edge survives the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_ack_q  <= 1'b0;
            r_lat    <= '0;
            r_fire   <= '0;
            r_sticky <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack_q <= ack;
            r_lat   <= w_next_lat;
            r_fire  <= w_viol;
            r_busy  <= (w_next_state == WAIT_ACK);
            if (clr) begin
                r_sticky <= w_viol;
                r_cnt    <= CNT_W'(w_any_viol);
            end else begin
                r_sticky <= r_sticky | w_viol;
                if (w_any_viol && !w_cnt_sat) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign fire       = r_fire;
    assign err_sticky = r_sticky;
    assign err_cnt    = r_cnt;
    assign busy       = r_busy;

endmodule

// File: rtl/handshake_monitor_mc.sv
// Passive multi-channel req/ack latency monitor; replicates hsmon_channel
// per channel and packs the per-channel results into flat output vectors.
module handshake_monitor_mc
    import hsmon_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MIN_ACK = 2,
    parameter int unsigned MAX_ACK = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        ack,
    output logic [NUM_CH*RULE_W-1:0] fire,
    output logic [NUM_CH*RULE_W-1:0] err_sticky,
    output logic [NUM_CH*CNT_W-1:0]  err_cnt,
    output logic [NUM_CH-1:0]        busy
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        hsmon_channel #(
            .MIN_ACK (MIN_ACK),
            .MAX_ACK (MAX_ACK),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (enable),
            .clr        (clr),
            .req        (req[c]),
            .ack        (ack[c]),
            .fire       (fire[c*RULE_W +: RULE_W]),
            .err_sticky (err_sticky[c*RULE_W +: RULE_W]),
            .err_cnt    (err_cnt[c*CNT_W +: CNT_W]),
            .busy       (busy[c])
        );
    end

endmodule

// File: tb/tb_handshake_monitor_mc.sv
// Scoreboard bench for handshake_monitor_mc: a timestamp-based protocol model
// queues expected outputs per edge; directed checks pin the key scenarios.
module tb_handshake_monitor_mc;

    localparam int NCH  = 4;
    localparam int MINA = 2;
    localparam int MAXA = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic clr;
    logic [NCH-1:0] req;
    logic [NCH-1:0] ack;

    logic [NCH*4-1:0] fire, sticky, s_fire, s_sticky;
    logic [NCH*8-1:0] cnt;
    logic [NCH*2-1:0] s_cnt;
    logic [NCH-1:0]   busy, s_busy;

    handshake_monitor_mc #(.NUM_CH(NCH), .MIN_ACK(MINA), .MAX_ACK(MAXA), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clr(clr), .req(req), .ack(ack),
        .fire(fire), .err_sticky(sticky), .err_cnt(cnt), .busy(busy)
    );

    handshake_monitor_mc #(.NUM_CH(NCH), .MIN_ACK(MINA), .MAX_ACK(MAXA), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clr(clr), .req(req), .ack(ack),
        .fire(s_fire), .err_sticky(s_sticky), .err_cnt(s_cnt), .busy(s_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH*4-1:0] fire;
        logic [NCH*4-1:0] sticky;
        logic [NCH*8-1:0] cnt;
        logic [NCH*2-1:0] cnt_s;
        logic [NCH-1:0]   busy;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // model state: 0 idle, 1 waiting, 2 acked, 3 timed out
    int       m_st[NCH];
    int       m_t0[NCH];
    logic     m_aq[NCH];
    logic [3:0] m_sticky[NCH];
    int       m_cnt[NCH];
    int       m_cnts[NCH];
    int       cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_st[c] = 0; m_t0[c] = 0; m_aq[c] = 1'b0;
            m_sticky[c] = 4'b0; m_cnt[c] = 0; m_cnts[c] = 0;
        end
        cyc = 0;
        exp_q.delete();
    endtask

    // Predict this edge from the current inputs, clock it, then score the DUTs
    task automatic tick();
        exp_t e, got;
        logic [3:0] v;
        logic edg;
        int lat;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            edg = ack[c] & ~m_aq[c];
            m_aq[c] = ack[c];
            v = 4'b0;
            lat = cyc - m_t0[c];
            if (!enable) m_st[c] = 0;
            else begin
                case (m_st[c])
                    0: if (req[c]) begin
                           m_t0[c] = cyc;
                           if (edg) begin v[1] = (MINA > 0); m_st[c] = 2; end
                           else m_st[c] = 1;
                       end else if (edg) v[0] = 1'b1;
                    1: if (edg) begin v[1] = (lat < MINA); m_st[c] = 2; end
                       else if (!req[c]) begin v[3] = 1'b1; m_st[c] = 0; end
                       else if (lat >= MAXA) begin v[2] = 1'b1; m_st[c] = 3; end
                    2: begin v[0] = edg; if (!req[c]) m_st[c] = 0; end
                    default: if (!req[c]) m_st[c] = 0;
                endcase
            end
            if (clr) begin
                m_sticky[c] = v;
                m_cnt[c]  = (v != 0) ? 1 : 0;
                m_cnts[c] = (v != 0) ? 1 : 0;
            end else begin
                m_sticky[c] = m_sticky[c] | v;
                if (v != 0 && m_cnt[c] < 255) m_cnt[c]++;
                if (v != 0 && m_cnts[c] < 3) m_cnts[c]++;
            end
            e.fire[c*4 +: 4]   = v;
            e.sticky[c*4 +: 4] = m_sticky[c];
            e.cnt[c*8 +: 8]    = 8'(m_cnt[c]);
            e.cnt_s[c*2 +: 2]  = 2'(m_cnts[c]);
            e.busy[c]          = (m_st[c] == 1);
        end
        exp_q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            got = exp_q.pop_front();
            chk("fire",     64'(fire),     64'(got.fire));
            chk("sticky",   64'(sticky),   64'(got.sticky));
            chk("cnt",      64'(cnt),      64'(got.cnt));
            chk("busy",     64'(busy),     64'(got.busy));
            chk("s_fire",   64'(s_fire),   64'(got.fire));
            chk("s_sticky", 64'(s_sticky), 64'(got.sticky));
            chk("s_cnt",    64'(s_cnt),    64'(got.cnt_s));
            chk("s_busy",   64'(s_busy),   64'(got.busy));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fire"},   64'(fire),   64'd0);
        chk({tag, "_sticky"}, 64'(sticky), 64'd0);
        chk({tag, "_cnt"},    64'(cnt),    64'd0);
        chk({tag, "_busy"},   64'(busy),   64'd0);
        chk({tag, "_s_cnt"},  64'(s_cnt),  64'd0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; clr = 1'b0; req = '0; ack = '0;
        model_reset();
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1; enable = 1'b1;

        // ch0 legal acks at L=2 and L=4
        req[0] = 1'b1; tick();
        chk("ch0_busy_wait", 64'(busy[0]), 64'd1);
        tick();
        ack[0] = 1'b1; tick();
        chk("ch0_l2_no_fire", 64'(fire), 64'd0);
        req[0] = 1'b0; ack[0] = 1'b0; tick();
        req[0] = 1'b1; ticks(4);
        chk("ch0_busy_l3", 64'(busy[0]), 64'd1);
        ack[0] = 1'b1; tick();
        chk("ch0_l4_no_fire", 64'(fire), 64'd0);
        req[0] = 1'b0; ack[0] = 1'b0; tick();
        chk("ch0_cnt_zero", 64'(cnt[7:0]), 64'd0);

        // ch1 early ack, then timeout
        req[1] = 1'b1; tick();
        ack[1] = 1'b1; tick();
        chk("ch1_early", 64'(fire[7:4]), 64'b0010);
        req[1] = 1'b0; ack[1] = 1'b0; tick();
        chk("ch1_early_1cyc", 64'(fire[5]), 64'd0);
        req[1] = 1'b1; ticks(4);
        chk("ch1_no_to_yet", 64'(fire[6]), 64'd0);
        tick();
        chk("ch1_timeout", 64'(fire[7:4]), 64'b0100);
        ack[1] = 1'b1; tick();
        chk("ch1_late_ack_ignored", 64'(fire[7:4]), 64'd0);
        req[1] = 1'b0; ack[1] = 1'b0; tick();
        chk("ch1_cnt2", 64'(cnt[15:8]), 64'd2);
        chk("ch1_sticky", 64'(sticky[6:5]), 64'b11);

        // ch2 req drop, then spurious ack
        req[2] = 1'b1; ticks(3);
        req[2] = 1'b0; tick();
        chk("ch2_req_drop", 64'(fire[11:8]), 64'b1000);
        ack[2] = 1'b1; tick();
        chk("ch2_spurious", 64'(fire[11:8]), 64'b0001);
        chk("others_quiet", 64'({fire[15:12], fire[7:0]}), 64'd0);
        ack[2] = 1'b0; tick();

        // ch3 saturation on the narrow counter, then clr colliding with EARLY
        for (int i = 0; i < 5; i++) begin
            ack[3] = 1'b1; tick();
            ack[3] = 1'b0; tick();
        end
        chk("ch3_sat_s", 64'(s_cnt[7:6]), 64'd3);
        chk("ch3_cnt5", 64'(cnt[31:24]), 64'd5);
        req[3] = 1'b1; tick();
        ack[3] = 1'b1; clr = 1'b1; tick();
        clr = 1'b0;
        chk("clr_sticky", 64'(sticky), 64'h2000);
        chk("clr_cnt", 64'(cnt), 64'h0100_0000);
        chk("clr_cnt_s", 64'(s_cnt), 64'h40);
        req[3] = 1'b0; ack[3] = 1'b0; tick();

        // enable drop mid-wait, re-enable with req held high
        req[0] = 1'b1; ticks(2);
        enable = 1'b0; tick();
        chk("dis_busy", 64'(busy[0]), 64'd0);
        chk("dis_fire", 64'(fire), 64'd0);
        ticks(2);
        enable = 1'b1; tick();
        chk("reen_busy", 64'(busy[0]), 64'd1);
        ticks(2);
        ack[0] = 1'b1; tick();
        chk("reen_l3_legal", 64'(fire), 64'd0);
        chk("reen_cnt0", 64'(cnt[7:0]), 64'd0);
        req[0] = 1'b0; ack[0] = 1'b0; tick();

        // async reset in the middle of a transaction
        req[1] = 1'b1; ticks(2);
        chk("pre_rst_busy", 64'(busy[1]), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        req = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/handshake_monitor_mc.md
Name: handshake_monitor_mc

Overview:
Native-RTL, parametrised successor to the single-channel OVL req/ack handshake checker, with no OVL library dependency.
- Monitors NUM_CH independent req/ack channels against a bounded-latency protocol.
- Reports per-channel, per-rule fire pulses, sticky error flags and saturating error counters.
- Sits beside bus masters/slaves as a passive observer; drives nothing into the DUT.

Parameters:
NUM_CH, 4, number of monitored req/ack channels (>=1)
MIN_ACK, 2, minimum legal ack latency in cycles (>=0)
MAX_ACK, 4, maximum legal ack latency in cycles (>=MIN_ACK, >=1)
CNT_W, 8, width of each per-channel saturating error counter

Ports:
clk  in  1  sampling clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = checking active; 0 = all FSMs held IDLE, no errors raised
clr  in  1  synchronous clear of err_sticky and err_cnt
req  in  NUM_CH  request per channel
ack  in  NUM_CH  acknowledge per channel
fire  out  NUM_CH*4  one-cycle violation pulses; channel c uses bits [4c+3:4c]
err_sticky  out  NUM_CH*4  sticky copy of fire, same bit layout
err_cnt  out  NUM_CH*CNT_W  per-channel count of cycles with any violation, saturating
busy  out  NUM_CH  channel FSM is in WAIT_ACK

Behaviour:
- Rule bits per channel: [0] SPURIOUS, [1] EARLY, [2] TIMEOUT, [3] REQ_DROP.
- Reset: all outputs 0, FSMs IDLE, ack_q 0, latency counters 0.
- ack edge = ack & ~ack_q, where ack_q is ack registered each cycle.
- Latency L = clock edges from the edge sampling req=1 in IDLE to the edge sampling the ack edge. Counter width is clog2(MAX_ACK+1).
- FSM per channel (enable=1):
  - IDLE:
    - req=1 -> WAIT_ACK, L=0.
    - A coincident ack edge counts as an ack at L=0: EARLY if MIN_ACK>0, legal otherwise; go to DONE.
    - Ack edge with req=0 -> SPURIOUS, stay in IDLE.
  - WAIT_ACK:
    - Ack edge with L<MIN_ACK -> EARLY, go to DONE.
    - Ack edge with MIN_ACK<=L<=MAX_ACK -> legal, go to DONE; req may drop on the same edge.
    - No ack edge, req=0 -> REQ_DROP, go to IDLE.
    - No ack edge, req=1, L==MAX_ACK -> TIMEOUT, go to TOUT.
    - Otherwise L++.
  - DONE: req=0 -> IDLE. A further ack edge -> SPURIOUS.
  - TOUT: wait for req=0, then go to IDLE. A late ack edge is ignored (already reported).
- Ack held high across a req rise produces no edge, so the transaction times out.
- fire is registered: a violation sampled at edge T pulses fire high for exactly the cycle after T. err_sticky sets on the same edge.
- err_cnt increments by 1 per cycle in which any of the channel's 4 bits fires, saturating at 2^CNT_W-1.
- clr clears err_sticky and err_cnt. A violation coincident with clr wins: sticky bit = new bit, count = 1. clr does not affect the FSMs or fire.
- enable=0: FSMs forced to IDLE, fire=0, sticky/counters hold. On re-enable, a req already high starts a new measurement (IDLE is level-triggered).
- Reset asserted mid-transaction: immediate return to reset values.
- Channels are fully independent; no cross-channel interaction.

Decomposition:
- Package hsmon_pkg holds:
  - the rule bit index constants (RULE_SPURIOUS=0, RULE_EARLY=1, RULE_TIMEOUT=2, RULE_REQ_DROP=3, RULE_W=4);
  - the channel-state enum {IDLE, WAIT_ACK, DONE, TOUT}.
- Sub-module hsmon_channel holds one channel's FSM, ack_q, latency counter, sticky flags and counter. It is instantiated NUM_CH times in a generate loop; the top level only fans out enable/clr and packs the outputs.

Test Plan:
(All scenarios use default parameters.)
- Legal latencies: ch0 req rises, ack edge at L=2, then at L=4 in separate transactions -> fire stays 0, err_cnt[0]=0, busy[0] high during the wait.
- Early and timeout: ch1 ack edge at L=1 -> fire[5] pulse 1 cycle. Next transaction with no ack for 5 edges -> fire[6] pulse at L=4. Then err_cnt[1]=2 and err_sticky[6:5]=2'b11.
- Req drop and spurious: ch2 req drops at L=3 without ack -> fire[11]. Ack pulse with req=0 -> fire[8]. Ch0/1/3 outputs remain 0.
- clr collision and saturation: with CNT_W=2, force 5 violations -> err_cnt saturates at 3. Assert clr on the same cycle as a new EARLY -> sticky shows only EARLY, count=1.
- Enable/reset: drop enable mid WAIT_ACK -> busy=0 and no fire. Re-enable with req high -> new measurement with legal ack at L=3 and no error. Assert reset_n low mid-transaction -> all outputs 0 asynchronously.
